control_multi_fsm: RTL
======================

Name: control_multi_fsm

Overview:
Multicycle control sequencer for the RV32I core. Decodes iOp/iFunct3/iFunct7 from the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback. One ALU and one unified memory are reused across cycles. Sits beside the multicycle datapath in CPU/ and drives all of its mux selects and write enables.

Parameters:
MEM_WAIT, 0, extra wait cycles per memory access (0..15); each memory state lasts MEM_WAIT+1 cycles.

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  synchronous reset, active-high
iOp  in  7  opcode from IR
iFunct3  in  3  funct3 from IR
iFunct7  in  7  funct7 from IR
iBranchC1  in  1  branch condition true (external comparator)
oEscreveIR  out  1  IR and PCBack load
oEscrevePC  out  1  PC load
oOrigPC  out  3  PC source: 000 ALU result, 001 ALUOut, 010 ALU result & ~1
oIouD  out  1  memory address: 0 PC, 1 ALUOut
oLeMem  out  1  memory read
oEscreveMem  out  1  memory write
oEscreveReg  out  1  register file write
oMemparaReg  out  3  rd source: 000 ALUOut, 001 MDR, 010 PC, 011 immediate
oOrigAULA  out  2  ALU A: 00 PCBack, 01 rs1, 10 PC
oOrigBULA  out  2  ALU B: 00 rs2, 01 const 4, 10 immediate
oOpALU  out  2  00 add, 01 compare/sub, 10 decode funct3/funct7
oEstado  out  4  current state code, debug
oTrap  out  1  invalid-instruction trap (see Optional Feature)

Behaviour:
- Clocking: iCLK and iRST (synchronous, active-high) are the only clock and reset.
- Reset: while iRST=1 at a rising edge, state <= FETCH and wait counter <= 0. Outputs are Moore decodes of state and are all 0 while iRST is high.
- Default value of every output in every state is 0 unless it is listed for that state below.
- States (oEstado code):
  - FETCH(0): oLeMem=1, oIouD=0, oOrigAULA=10, oOrigBULA=01, oOpALU=00. On the last wait cycle only: oEscreveIR=1, oEscrevePC=1, oOrigPC=000. Next state is DECODE.
  - DECODE(1): ALUOut <= PCBack+imm (oOrigAULA=00, oOrigBULA=10, oOpALU=00). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other opcode -> FETCH
  - EXEC_R(2): oOrigAULA=01, oOrigBULA=00, oOpALU=10. Next state WB_ALU.
  - EXEC_I(3): oOrigAULA=01, oOrigBULA=10, oOpALU=10. Next state WB_ALU.
  - ADDR(4): oOrigAULA=01, oOrigBULA=10, oOpALU=00. Next state MEM_RD if iOp=0000011, else MEM_WR.
  - MEM_RD(5): oLeMem=1, oIouD=1, held MEM_WAIT+1 cycles. Next state MEM_WB.
  - MEM_WB(6): oEscreveReg=1, oMemparaReg=001. Next state FETCH.
  - MEM_WR(7): oEscreveMem=1, oIouD=1, held MEM_WAIT+1 cycles. Next state FETCH.
  - BRANCH(8): oOrigAULA=01, oOrigBULA=00, oOpALU=01. oEscrevePC=iBranchC1, oOrigPC=001. Next state FETCH.
  - JAL(9): oEscrevePC=1, oOrigPC=001, oEscreveReg=1, oMemparaReg=010. Next state FETCH.
  - JALR(10): oOrigAULA=01, oOrigBULA=10, oOpALU=00, oEscrevePC=1, oOrigPC=010, oEscreveReg=1, oMemparaReg=010. Next state FETCH.
  - LUI(11): oEscreveReg=1, oMemparaReg=011. Next state FETCH.
  - AUIPC(12): oOrigAULA=00, oOrigBULA=10, oOpALU=00. Next state WB_ALU.
  - WB_ALU(13): oEscreveReg=1, oMemparaReg=000. Next state FETCH.
  - TRAP(14): see Optional Feature.
- Link value: PC already holds PC+4 at the write edge. In JAL/JALR the rd write and the PC write land on the same edge, so rd receives the old PC+4.
- Cycle counts with MEM_WAIT=0:
  - branch, JAL, JALR, LUI: 3
  - R-type, I-type, AUIPC, store: 4
  - load: 5
- Each memory state adds MEM_WAIT cycles.
- Wait counter:
  - 4 bits; counts 0..MEM_WAIT inside FETCH, MEM_RD and MEM_WR.
  - Cleared on every state change and on reset.
  - Reset mid-wait abandons the access; no IR or PC write occurs.
- iFunct3/iFunct7 do not affect sequencing. With oOpALU=10 they are decoded by the ALU control.

Optional Feature:
MULTI_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP(14).
  - TRAP holds oTrap=1 with all enables 0 until iRST.
- Undefined:
  - An unrecognised opcode returns to FETCH; the instruction executes as a NOP because PC was already advanced.
  - State 14 is unreachable and oTrap is tied 0.

Test Plan:
- Reset then R-type add (iOp=0110011), MEM_WAIT=0 -> oEstado 0,1,2,13,0. oEscreveReg=1 only in cycle 4 (oMemparaReg=000).
- Load (0000011), MEM_WAIT=2 -> FETCH lasts 3 cycles, with oEscreveIR/oEscrevePC only in the 3rd. Then 1,4; then MEM_RD 3 cycles with oLeMem=1, oIouD=1; then MEM_WB with oMemparaReg=001. Total 9 cycles.
- Branch (1100011), first with iBranchC1=0, then with iBranchC1=1 -> 3 cycles each. oEscrevePC=0 in BRANCH for the first; oEscrevePC=1 with oOrigPC=001 for the second.
- JALR (1100111) -> in state 10: oEscrevePC=1, oOrigPC=010, oEscreveReg=1, oMemparaReg=010, all in the same cycle.
- iRST asserted during the 2nd cycle of MEM_WR with MEM_WAIT=3 -> next state FETCH, counter 0, oEscreveMem=0 from the reset cycle on.
- iOp=1111111 -> returns to FETCH after DECODE with MULTI_TRAP_EN undefined. With MULTI_TRAP_EN defined, enters state 14 and holds oTrap=1 for 10+ cycles until iRST.

Source files
------------

// File: rtl/control_multi_fsm.sv
// control_multi_fsm: multicycle control sequencer for the RV32I core.
// Steps the shared datapath (one ALU, one unified memory) through fetch,
// decode, execute, memory and writeback, and drives every mux select and
// write enable of the multicycle datapath.
//
// Build option: define MULTI_TRAP_EN to send unrecognised opcodes to a
// sticky TRAP state (oTrap=1, all enables 0, left only through iRST).
// Without it, unrecognised opcodes fall back to FETCH and act as NOPs.
module control_multi_fsm #(
  parameter int unsigned MEM_WAIT = 0  // extra wait cycles per memory access (0..15)
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iOp,
  input  logic [2:0] iFunct3,
  input  logic [6:0] iFunct7,
  input  logic       iBranchC1,
  output logic       oEscreveIR,
  output logic       oEscrevePC,
  output logic [2:0] oOrigPC,
  output logic       oIouD,
  output logic       oLeMem,
  output logic       oEscreveMem,
  output logic       oEscreveReg,
  output logic [2:0] oMemparaReg,
  output logic [1:0] oOrigAULA,
  output logic [1:0] oOrigBULA,
  output logic [1:0] oOpALU,
  output logic [3:0] oEstado,
  output logic       oTrap
);

  // State codes double as the oEstado debug value.
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WB = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JAL    = 4'd9;
  localparam logic [3:0] S_JALR   = 4'd10;
  localparam logic [3:0] S_LUI    = 4'd11;
  localparam logic [3:0] S_AUIPC  = 4'd12;
  localparam logic [3:0] S_WB_ALU = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  // RV32I major opcodes.
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Mux select encodings.
  localparam logic [2:0] PC_ALU      = 3'b000;
  localparam logic [2:0] PC_ALUOUT   = 3'b001;
  localparam logic [2:0] PC_ALU_EVEN = 3'b010;
  localparam logic [2:0] RD_ALUOUT   = 3'b000;
  localparam logic [2:0] RD_MDR      = 3'b001;
  localparam logic [2:0] RD_PC       = 3'b010;
  localparam logic [2:0] RD_IMM      = 3'b011;
  localparam logic [1:0] A_PCBACK    = 2'b00;
  localparam logic [1:0] A_RS1       = 2'b01;
  localparam logic [1:0] A_PC        = 2'b10;
  localparam logic [1:0] B_RS2       = 2'b00;
  localparam logic [1:0] B_FOUR      = 2'b01;
  localparam logic [1:0] B_IMM       = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_CMP     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] wait_cnt;
  logic       wait_last;
  logic       wait_state;

  // funct3/funct7 are decoded by the ALU control, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^{iFunct3, iFunct7};

  assign wait_last  = (wait_cnt == WAIT_LAST);
  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // Next-state selection; memory-touching states advance only on their last wait cycle.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    next_state = state;
    case (state)
      S_FETCH:  if (wait_last) next_state = S_DECODE;
      S_DECODE: begin
        case (iOp)
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_LOAD, OP_STORE: next_state = S_ADDR;
          OP_BR:             next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
`ifdef MULTI_TRAP_EN
          default:           next_state = S_TRAP;
`else
          // PC was already advanced in FETCH, so this behaves as a NOP.
          default:           next_state = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: next_state = S_WB_ALU;
      S_EXEC_I: next_state = S_WB_ALU;
      S_ADDR:   next_state = (iOp == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (wait_last) next_state = S_MEM_WB;
      S_MEM_WB: next_state = S_FETCH;
      S_MEM_WR: if (wait_last) next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JAL:    next_state = S_FETCH;
      S_JALR:   next_state = S_FETCH;
      S_LUI:    next_state = S_FETCH;
      S_AUIPC:  next_state = S_WB_ALU;
      S_WB_ALU: next_state = S_FETCH;
`ifdef MULTI_TRAP_EN
      S_TRAP:   next_state = S_TRAP;
`endif
      default:  next_state = S_FETCH;
    endcase
  end

  // State and wait-counter registers; the counter restarts on every state change.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iRST) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= 4'd0;
      end else if (wait_state && !wait_last) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Moore output decode of the current state, forced to 0 while iRST is high.
  always_comb begin
    oEscreveIR  = 1'b0;
    oEscrevePC  = 1'b0;
    oOrigPC     = PC_ALU;
    oIouD       = 1'b0;
    oLeMem      = 1'b0;
    oEscreveMem = 1'b0;
    oEscreveReg = 1'b0;
    oMemparaReg = RD_ALUOUT;
    oOrigAULA   = A_PCBACK;
    oOrigBULA   = B_RS2;
    oOpALU      = ALU_ADD;
    oEstado     = state;
    oTrap       = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR on the last one.
        oLeMem    = 1'b1;
        oIouD     = 1'b0;
        oOrigAULA = A_PC;
        oOrigBULA = B_FOUR;
        oOpALU    = ALU_ADD;
        if (wait_last) begin
          oEscreveIR = 1'b1;
          oEscrevePC = 1'b1;
          oOrigPC    = PC_ALU;
        end
      end
      S_DECODE: begin
        // Speculative branch/jump target: ALUOut <= PCBack + imm.
        oOrigAULA = A_PCBACK;
        oOrigBULA = B_IMM;
        oOpALU    = ALU_ADD;
      end
      S_EXEC_R: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_RS2;
        oOpALU    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        oOpALU    = ALU_FUNCT;
      end
      S_ADDR: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        oOpALU    = ALU_ADD;
      end
      S_MEM_RD: begin
        oLeMem = 1'b1;
        oIouD  = 1'b1;
      end
      S_MEM_WB: begin
        oEscreveReg = 1'b1;
        oMemparaReg = RD_MDR;
      end
      S_MEM_WR: begin
        oEscreveMem = 1'b1;
        oIouD       = 1'b1;
      end
      S_BRANCH: begin
        // Target already sits in ALUOut from DECODE; the ALU is free for the compare.
        oOrigAULA  = A_RS1;
        oOrigBULA  = B_RS2;
        oOpALU     = ALU_CMP;
        oEscrevePC = iBranchC1;
        oOrigPC    = PC_ALUOUT;
      end
      S_JAL: begin
        // rd and PC are written on the same edge, so rd captures the old PC+4.
        oEscrevePC  = 1'b1;
        oOrigPC     = PC_ALUOUT;
        oEscreveReg = 1'b1;
        oMemparaReg = RD_PC;
      end
      S_JALR: begin
        oOrigAULA   = A_RS1;
        oOrigBULA   = B_IMM;
        oOpALU      = ALU_ADD;
        oEscrevePC  = 1'b1;
        oOrigPC     = PC_ALU_EVEN;
        oEscreveReg = 1'b1;
        oMemparaReg = RD_PC;
      end
      S_LUI: begin
        oEscreveReg = 1'b1;
        oMemparaReg = RD_IMM;
      end
      S_AUIPC: begin
        oOrigAULA = A_PCBACK;
        oOrigBULA = B_IMM;
        oOpALU    = ALU_ADD;
      end
      S_WB_ALU: begin
        oEscreveReg = 1'b1;
        oMemparaReg = RD_ALUOUT;
      end
`ifdef MULTI_TRAP_EN
      S_TRAP: begin
        oTrap = 1'b1;
      end
`endif
      default: begin
        oEstado = state;
      end
    endcase
    if (iRST) begin
      oEscreveIR  = 1'b0;
      oEscrevePC  = 1'b0;
      oOrigPC     = 3'b000;
      oIouD       = 1'b0;
      oLeMem      = 1'b0;
      oEscreveMem = 1'b0;
      oEscreveReg = 1'b0;
      oMemparaReg = 3'b000;
      oOrigAULA   = 2'b00;
      oOrigBULA   = 2'b00;
      oOpALU      = 2'b00;
      oEstado     = 4'd0;
      oTrap       = 1'b0;
    end
  end

endmodule
